// File: rtl/hex_sched_pkg.sv
// Shared types and constants for the hex display scheduler: FSM states,
// the blank segment pattern and the active-low hex glyph table.
package hex_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHOW    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Index = nibble value; bit6=g ... bit0=a, active low.
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational nibble to active-low 7-segment glyph decoder.
module hex7seg_dec
  import hex_sched_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_GLYPH[nib_i];

endmodule

// File: rtl/hex_display_sched.sv
// Round-robin time-slot owner of the four HEX digits with registered decode.
// Optional blinking of the owner's digits is built when HEX_DISPLAY_SCHED_BLINK_EN is defined.
module hex_display_sched
  import hex_sched_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int TICK_DIV    = 5_000_000,
  parameter int DWELL_TICKS = 8
) (
  input  logic                ck,
  input  logic                rs,
  input  logic [NREQ-1:0]     req,
  input  logic [16*NREQ-1:0]  data,
  input  logic [NREQ-1:0]     blink,
  output logic [NREQ-1:0]     grant,
  output logic                done,
  output logic [6:0]          hex0,
  output logic [6:0]          hex1,
  output logic [6:0]          hex2,
  output logic [6:0]          hex3
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = $clog2(DWELL_TICKS) + 1;
  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_TICKS - 1);

  if (NREQ < 2) begin : g_nreq_check
    $error("hex_display_sched: NREQ must be at least 2");
  end

  // First set request at or above ptr, wrapping around.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   ptr);
    logic [IW-1:0] win;
    logic          found;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      int idx;
      idx = (int'(ptr) + i) % NREQ;
      if (!found && r[idx]) begin
        win   = IW'(idx);
        found = 1'b1;
      end
    end
    return win;
  endfunction

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [DW-1:0]   dwell_q, dwell_d;
  logic            done_q, done_d;
  logic [3:0][6:0] hex_q, hex_d;

  logic [IW-1:0]   win;
  logic            tick;
  logic            slot_exit;
  logic            blank;
  logic [15:0]     own_data;
  logic [3:0][6:0] seg;

  assign win       = rr_pick(req, ptr_q);
  assign tick      = (tick_q == TICK_LAST);
  assign slot_exit = (state_q == SHOW) &&
                     ((tick && (dwell_q == DWELL_LAST)) || !req[owner_q]);
  assign own_data  = data[{owner_q, 4'b0000} +: 16];

  for (genvar g = 0; g < 4; g++) begin : g_dec
    hex7seg_dec u_dec (
      .nib_i (own_data[4*g +: 4]),
      .seg_o (seg[g])
    );
  end

`ifdef HEX_DISPLAY_SCHED_BLINK_EN
  logic phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (state_q == IDLE && |req)     phase_d = 1'b0;
    else if (state_q == SHOW && tick) phase_d = ~phase_q;
  end

  always_ff @(posedge ck) begin
    if (rs) phase_q <= 1'b0;
    else    phase_q <= phase_d;
  end

  assign blank = blink[owner_q] & phase_q;
`else
  logic unused_blink;
  assign unused_blink = ^blink;
  assign blank        = 1'b0;
`endif

  always_comb begin
    // NOTE: every next-state signal takes its held value first, so no path leaves one unassigned and infers a latch.
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    tick_d  = tick_q;
    dwell_d = dwell_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = NREQ'(1) << win;
          owner_d = win;
          ptr_d   = IW'((int'(win) + 1) % NREQ);
          tick_d  = '0;
          dwell_d = '0;
          state_d = SHOW;
        end
      end
      SHOW: begin
        tick_d = tick ? '0 : tick_q + 1'b1;
        if (tick) dwell_d = dwell_q + 1'b1;
        if (slot_exit) begin
          grant_d = '0;
          done_d  = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The digits go dark on the exit edge together with grant.
  always_comb begin
    hex_d = {4{SEG_OFF}};
    if (state_q == SHOW && !slot_exit && !blank) hex_d = seg;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ck) begin
    if (rs) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      tick_q  <= '0;
      dwell_q <= '0;
      done_q  <= 1'b0;
      hex_q   <= {4{SEG_OFF}};
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      tick_q  <= tick_d;
      dwell_q <= dwell_d;
      done_q  <= done_d;
      hex_q   <= hex_d;
    end
  end

  assign grant = grant_q;
  assign done  = done_q;
  assign hex0  = hex_q[0];
  assign hex1  = hex_q[1];
  assign hex2  = hex_q[2];
  assign hex3  = hex_q[3];

endmodule

// File: tb/tb_hex_display_sched.sv
// Scoreboard bench for hex_display_sched: the stimulus queues expected grant,
// release, digit and snapshot events; a negedge monitor pops and compares them.
module tb_hex_display_sched;

  localparam int NREQ        = 4;
  localparam int TICK_DIV    = 4;
  localparam int DWELL_TICKS = 2;
  localparam int CYCLE_LIMIT = 500;

  localparam logic [27:0] OFF4  = {4{7'h7F}};
  localparam logic [27:0] H1234 = {7'h79, 7'h24, 7'h30, 7'h19};
  localparam logic [27:0] H5678 = {7'h12, 7'h02, 7'h78, 7'h00};
  localparam logic [27:0] H9ABC = {7'h10, 7'h08, 7'h03, 7'h46};
  localparam logic [27:0] H8888 = {4{7'h00}};

  typedef enum logic [2:0] {EV_SNAP, EV_GRANT, EV_REL, EV_HEX, EV_DONE} ev_kind_t;
  typedef struct packed {
    ev_kind_t    kind;
    logic [39:0] val;
  } ev_t;

  logic                ck = 1'b0;
  logic                rs;
  logic [NREQ-1:0]     req;
  logic [16*NREQ-1:0]  data;
  logic [NREQ-1:0]     blink;
  logic [NREQ-1:0]     grant;
  logic                done;
  logic [6:0]          hex0, hex1, hex2, hex3;
  logic [27:0]         hex_bus;

  ev_t exp_q[$];
  int  n_checks  = 0;
  int  n_fail    = 0;
  int  pcnt      = 0;
  int  snap_req  = 0;
  bit  stim_done = 1'b0;

  hex_display_sched #(
    .NREQ        (NREQ),
    .TICK_DIV    (TICK_DIV),
    .DWELL_TICKS (DWELL_TICKS)
  ) dut (
    .ck    (ck),
    .rs    (rs),
    .req   (req),
    .data  (data),
    .blink (blink),
    .grant (grant),
    .done  (done),
    .hex0  (hex0),
    .hex1  (hex1),
    .hex2  (hex2),
    .hex3  (hex3)
  );

  assign hex_bus = {hex3, hex2, hex1, hex0};

  always #5 ck = ~ck;
  always @(posedge ck) pcnt <= pcnt + 1;

  // Returns 1 time unit after the n-th rising edge.
  task automatic at_edge(input int n);
    wait (pcnt >= n);
    #1;
  endtask

  function automatic void exp_ev(input ev_kind_t k, input logic [39:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  function automatic void exp_grant(input int gap, input logic [3:0] g);
    exp_ev(EV_GRANT, 40'({8'(gap), g}));
  endfunction

  function automatic void exp_rel(input int held);
    exp_ev(EV_REL, 40'({1'b1, 8'(held)}));
  endfunction

  function automatic void exp_hex(input logic [27:0] h);
    exp_ev(EV_HEX, 40'(h));
  endfunction

  function automatic void exp_reset_snap();
    exp_ev(EV_SNAP, 40'({1'b0, 4'b0000, OFF4}));
  endfunction

  task automatic observe(input ev_kind_t k, input logic [39:0] v, input int cyc);
    ev_t e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_%s: got %h, nothing expected (cycle %0d)", k.name(), v, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e.kind !== k || e.val !== v)
      begin
        n_fail++;
        $display("FAIL %s: got %s %h, expected %s %h (cycle %0d)",
                 e.kind.name(), k.name(), v, e.kind.name(), e.val, cyc);
      end
    end
  endtask

  // Stimulus: Pk = k-th rising edge; inputs change 1 unit after it.
  initial begin
    rs    = 1'b1;
    req   = 4'b1111;
    blink = 4'b0000;
    data  = {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234};

    at_edge(2);
    exp_reset_snap();
    snap_req++;
    rs = 1'b0;
    // Gap counts negedges from the last one that saw rs high.
    exp_grant(2, 4'b0001);
    exp_hex(H1234);
    exp_rel(8);
    exp_hex(OFF4);

    at_edge(3);
    req = 4'b0001;
    exp_grant(2, 4'b0001);
    exp_hex(H1234);

    at_edge(15);
    req = 4'b0101;
    exp_rel(8);
    exp_hex(OFF4);
    exp_grant(2, 4'b0100);
    exp_hex(H9ABC);
    exp_rel(8);
    exp_hex(OFF4);
    exp_grant(2, 4'b0001);
    exp_hex(H1234);
    exp_rel(8);
    exp_hex(OFF4);
    exp_grant(2, 4'b0100);
    exp_hex(H9ABC);

    at_edge(45);
    req = 4'b0111;
    exp_rel(8);
    exp_hex(OFF4);
    exp_grant(2, 4'b0001);
    exp_hex(H1234);

    at_edge(55);
    req = 4'b0110;
    exp_rel(3);
    exp_hex(OFF4);
    exp_grant(2, 4'b0010);
    exp_hex(H5678);

    at_edge(65);
    req = 4'b0100;
    exp_rel(8);
    exp_hex(OFF4);
    exp_grant(2, 4'b0100);
    exp_hex(H9ABC);

    at_edge(70);
    rs = 1'b1;
    at_edge(71);
    exp_reset_snap();
    snap_req++;

    at_edge(72);
    rs          = 1'b0;
    req         = 4'b0101;
    blink       = 4'b0001;
    data[15:0]  = 16'h8888;
    exp_grant(2, 4'b0001);
    exp_hex(H8888);
`ifdef HEX_DISPLAY_SCHED_BLINK_EN
    exp_hex(OFF4);
    exp_rel(8);
`else
    exp_rel(8);
    exp_hex(OFF4);
`endif

    at_edge(81);
    req = 4'b0000;
    at_edge(90);
    stim_done = 1'b1;
  end

  // Monitor: turns output changes into events and checks them against the queue.
  initial begin : monitor
    logic [3:0]  prev_grant;
    logic [27:0] prev_hex;
    int          cyc;
    int          rise_cyc;
    int          fall_cyc;
    int          snap_seen;
    ev_t         e;
    prev_grant = '0;
    prev_hex   = OFF4;
    cyc        = 0;
    rise_cyc   = 0;
    fall_cyc   = 0;
    snap_seen  = 0;
    forever begin
      @(negedge ck);
      cyc++;
      if (rs) begin
        prev_grant = grant;
        prev_hex   = hex_bus;
        fall_cyc   = cyc;
      end else begin
        if (grant !== prev_grant) begin
          if (grant != '0) begin
            rise_cyc = cyc;
            observe(EV_GRANT, 40'({8'(cyc - fall_cyc), grant}), cyc);
          end else begin
            observe(EV_REL, 40'({done, 8'(cyc - rise_cyc)}), cyc);
            fall_cyc = cyc;
          end
        end else if (done !== 1'b0) begin
          observe(EV_DONE, 40'(done), cyc);
        end
        if (hex_bus !== prev_hex) observe(EV_HEX, 40'(hex_bus), cyc);
        prev_grant = grant;
        prev_hex   = hex_bus;
      end
      if (snap_req != snap_seen) begin
        snap_seen++;
        observe(EV_SNAP, 40'({done, grant, hex_bus}), cyc);
      end
      if (stim_done || cyc > CYCLE_LIMIT) begin
        if (!stim_done) begin
          n_checks++;
          n_fail++;
          $display("FAIL timeout: stimulus still running at cycle %0d, limit %0d", cyc, CYCLE_LIMIT);
        end
        while (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          n_checks++;
          n_fail++;
          $display("FAIL missing_%s: got nothing, expected %h", e.kind.name(), e.val);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

endmodule
